btn_event: RTL and testbench

//   Converts a debounced push-button level into single-cycle events for the

---
 rtl/btn_event.sv | 213 +++++++++++++++++++++
 tb/tb_btn_event.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event.sv
// btn_event: turns a debounced button level into single-cycle press,
// release and auto-repeat events, plus a long-hold level.
// The release pulse port is named btn_release because "release" is a
// reserved word in SystemVerilog. All outputs come straight from flops.

// Property checker for the event outputs; only carries assertions.
module btn_event_chk (
  input logic clk,
  input logic rst_n,
  input logic press,
  input logic btn_release,
  input logic rpt,
  input logic step,
  input logic held
);

  // At most one of the three event pulses may be active in a cycle.
  a_one_event: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({press, btn_release, rpt}))
    else $error("btn_event_chk: more than one event pulse active");

  // The single-step strobe is exactly press or repeat.
  a_step_def: assert property (@(posedge clk) disable iff (!rst_n)
    step == (press | rpt))
    else $error("btn_event_chk: step differs from press|rpt");

  // A release pulse never coexists with step or with the held level.
  a_release_clean: assert property (@(posedge clk) disable iff (!rst_n)
    btn_release |-> (!step && !held))
    else $error("btn_event_chk: release overlaps step or held");

endmodule

module btn_event #(
  parameter int unsigned HOLD_CYCLES   = 32'd50000000,
  parameter int unsigned REPEAT_CYCLES = 32'd10000000,
  parameter int unsigned CNT_W         = 32'd32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic en_repeat,
  output logic press,
  output logic btn_release,
  output logic rpt,
  output logic step,
  output logic held
);

  // Terminal counts: the counter is compared against these before it
  // would increment, so the first repeat lands HOLD_CYCLES after press.
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             btn_q_r;
  logic             rise_s;
  logic             fall_s;

  logic             press_r;
  logic             release_r;
  logic             rpt_r;
  logic             step_r;
  logic             held_r;

  logic             press_s;
  logic             release_s;
  logic             rpt_s;
  logic             step_s;
  logic             held_s;

  // Edge detect against the previous-cycle button level.
  always_comb begin
    rise_s = btn & ~btn_q_r;
    fall_s = ~btn & btn_q_r;
  end

  // Button history flop; cleared by reset so a still-held button re-arms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q_r <= 1'b0;
    end else begin
      btn_q_r <= btn;
    end
  end

  // Next-state, counter and event decode for the hold/repeat sequencer.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    press_s   = 1'b0;
    release_s = fall_s;
    rpt_s     = 1'b0;
    held_s    = held_r;

    case (state_r)
      ST_IDLE: begin
        held_s = 1'b0;
        if (rise_s) begin
          press_s = 1'b1;
          state_s = ST_HOLD;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end
      end

      ST_HOLD: begin
        if (fall_s) begin
          // Release beats a terminal count landing in the same cycle.
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
          held_s  = 1'b0;
        end else if (cnt_r == HOLD_LAST) begin
          held_s = 1'b1;
          if (en_repeat) begin
            rpt_s   = 1'b1;
            state_s = ST_REPEAT;
            cnt_s   = CNT_ZERO;
          end else begin
            // Park at the terminal count so enabling repeat fires at once.
            state_s = ST_HOLD;
            cnt_s   = HOLD_LAST;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_REPEAT: begin
        if (fall_s) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
          held_s  = 1'b0;
        end else if (!en_repeat) begin
          // Repeat switched off: fall back to the saturated hold point.
          state_s = ST_HOLD;
          cnt_s   = HOLD_LAST;
        end else if (cnt_r == REPEAT_LAST) begin
          rpt_s = 1'b1;
          cnt_s = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        held_s  = 1'b0;
      end
    endcase

    step_s = press_s | rpt_s;
  end

  // Sequencer state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Output registers; every event is visible the cycle after its cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      rpt_r     <= 1'b0;
      step_r    <= 1'b0;
      held_r    <= 1'b0;
    end else begin
      press_r   <= press_s;
      release_r <= release_s;
      rpt_r     <= rpt_s;
      step_r    <= step_s;
      held_r    <= held_s;
    end
  end

  assign press       = press_r;
  assign btn_release = release_r;
  assign rpt         = rpt_r;
  assign step        = step_r;
  assign held        = held_r;

  btn_event_chk u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .press       (press_r),
    .btn_release (release_r),
    .rpt         (rpt_r),
    .step        (step_r),
    .held        (held_r)
  );

endmodule

// File: tb/tb_btn_event.sv
// Bench for btn_event: directed scenarios followed by random button
// activity. A timestamp-based reference model predicts each output cycle;
// predictions are queued and a monitor compares them on the falling edge.
module tb_btn_event;

  localparam int HOLD = 4;
  localparam int REP  = 2;

  logic clk;
  logic rst_n;
  logic btn;
  logic en_repeat;
  logic press;
  logic btn_release;
  logic rpt;
  logic step;
  logic held;

  btn_event #(
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .en_repeat   (en_repeat),
    .press       (press),
    .btn_release (btn_release),
    .rpt         (rpt),
    .step        (step),
    .held        (held)
  );

  typedef struct {
    int         due;
    logic [4:0] v;    // {press, release, rpt, step, held}
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: absolute cycle numbers instead of a counter.
  logic m_bq;
  bit   m_pressed;
  bit   m_held;
  int   m_due;      // earliest output cycle for the next repeat

  logic rnd_b;
  logic rnd_e;
  int   rnd_len;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Predict the outputs produced by sampling (b, e) at the next posedge.
  task automatic predict(input logic b, input logic e);
    int   o;
    logic p;
    logic r;
    logic rp;
    exp_t x;
    o  = cyc + 1;
    p  = b & ~m_bq;
    r  = ~b & m_bq;
    rp = 1'b0;
    if (p) begin
      m_pressed = 1'b1;
      m_held    = 1'b0;
      m_due     = o + HOLD;
    end else if (r) begin
      m_pressed = 1'b0;
      m_held    = 1'b0;
    end else if (m_pressed) begin
      // Once held, disabling repeat makes the next enabled cycle fire.
      if (m_held && !e && (m_due > o + 1)) m_due = o + 1;
      if (o >= m_due) begin
        m_held = 1'b1;
        if (e) begin
          rp    = 1'b1;
          m_due = o + REP;
        end
      end
    end
    m_bq  = b;
    x.due = o;
    x.v   = {p, r, rp, p | rp, m_held};
    sb_q.push_back(x);
  endtask

  task automatic apply(input logic b, input logic e);
    @(posedge clk);
    #1;
    btn       = b;
    en_repeat = e;
    predict(b, e);
  endtask

  task automatic reset_pulse(input int hold_cycles);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({press, btn_release, rpt, step, held} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, expected 00000",
               {press, btn_release, rpt, step, held});
    end
    sb_q.delete();
    repeat (hold_cycles) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n     = 1'b1;
    m_bq      = 1'b0;
    m_pressed = 1'b0;
    m_held    = 1'b0;
    m_due     = 0;
    predict(btn, en_repeat);
  endtask

  // Monitor: compare the DUT outputs against the prediction due this cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        mon_x = sb_q.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL stale_prediction: due cycle %0d still queued at cycle %0d",
                 mon_x.due, cyc);
      end
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        mon_x = sb_q.pop_front();
        n_vec++;
        if ({press, btn_release, rpt, step, held} !== mon_x.v) begin
          n_err++;
          $display("FAIL outputs cycle %0d: got press/rel/rpt/step/held=%b, expected %b",
                   cyc, {press, btn_release, rpt, step, held}, mon_x.v);
        end
      end
    end
  end

  // Stimulus: directed scenarios, then random runs with occasional resets.
  initial begin
    rst_n     = 1'b1;
    btn       = 1'b0;
    en_repeat = 1'b0;
    m_bq      = 1'b0;
    m_pressed = 1'b0;
    m_held    = 1'b0;
    m_due     = 0;
    reset_pulse(2);

    // Long hold with repeat enabled.
    repeat (3)  apply(1'b0, 1'b1);
    repeat (12) apply(1'b1, 1'b1);
    repeat (3)  apply(1'b0, 1'b1);

    // Long hold with repeat disabled.
    repeat (12) apply(1'b1, 1'b0);
    repeat (3)  apply(1'b0, 1'b0);

    // One-cycle glitch.
    apply(1'b1, 1'b1);
    repeat (4) apply(1'b0, 1'b1);

    // Fall exactly at the terminal hold count.
    repeat (4) apply(1'b1, 1'b1);
    repeat (3) apply(1'b0, 1'b1);

    // Repeat dropped mid-sequence, then re-enabled.
    repeat (8) apply(1'b1, 1'b1);
    repeat (2) apply(1'b1, 1'b0);
    repeat (4) apply(1'b1, 1'b1);
    repeat (3) apply(1'b0, 1'b1);

    // Repeat enabled only after the hold point has saturated.
    repeat (7) apply(1'b1, 1'b0);
    repeat (5) apply(1'b1, 1'b1);
    repeat (3) apply(1'b0, 1'b1);

    // Reset while the button is held.
    repeat (6) apply(1'b1, 1'b1);
    reset_pulse(2);
    repeat (10) apply(1'b1, 1'b1);
    repeat (3)  apply(1'b0, 1'b1);

    // Random runs of button level with a jittery repeat enable.
    rnd_b = 1'b0;
    for (int i = 0; i < 80; i++) begin
      rnd_b   = ~rnd_b;
      rnd_len = $urandom_range(1, 14);
      for (int j = 0; j < rnd_len; j++) begin
        rnd_e = ($urandom_range(0, 3) != 0);
        apply(rnd_b, rnd_e);
      end
      if ($urandom_range(0, 15) == 0) reset_pulse($urandom_range(1, 3));
    end
    repeat (3) apply(1'b0, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d predictions never compared, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
